// File: rtl/int_freelist.sv
// int_freelist -- physical integer register free list for rename.
//
// Holds the physical indices that are not mapped to any architectural
// register. Rename takes up to ALLOC_WIDTH of them per cycle, commit retires
// allocations, and retired stale mappings come back through the free ports.
// A speculative head and a committed head are kept so that a squash hands
// every uncommitted allocation back to the list in a single cycle.
//
// Optional build macro: FREELIST_DUPCHK_EN adds in-list tracking and the
// sticky o_dup_err output, which flags an index being freed twice.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   o_can_alloc      at least ALLOC_WIDTH indices are free
//   i_alloc_vld      per-lane allocation request (contiguous from lane 0)
//   o_alloc_iprIdx   index offered to each allocation lane
//   i_commit_cnt     number of allocations retired this cycle
//   i_free_vld       per-lane free valid
//   i_free_iprIdx    per-lane freed index (index 0 is dropped)
//   i_squash         return all uncommitted allocations to the list
//   o_free_count     free entries counted from the speculative head
//   o_dup_err        (FREELIST_DUPCHK_EN only) sticky double-free flag

`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif

module int_freelist #(
  parameter int SIZE        = 80,
  parameter int ARCH_NUM    = 32,
  parameter int ALLOC_WIDTH = `RENAME_WIDTH,
  parameter int FREE_WIDTH  = `RENAME_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        rst,
  output logic                                        o_can_alloc,
  input  logic [ALLOC_WIDTH-1:0]                      i_alloc_vld,
  output logic [ALLOC_WIDTH-1:0][$clog2(SIZE)-1:0]    o_alloc_iprIdx,
  input  logic [$clog2(ALLOC_WIDTH+1)-1:0]            i_commit_cnt,
  input  logic [FREE_WIDTH-1:0]                       i_free_vld,
  input  logic [FREE_WIDTH-1:0][$clog2(SIZE)-1:0]     i_free_iprIdx,
  input  logic                                        i_squash,
  output logic [$clog2(SIZE-ARCH_NUM+1)-1:0]          o_free_count
`ifdef FREELIST_DUPCHK_EN
  ,output logic                                       o_dup_err
`endif
);

  localparam int DEPTH = SIZE - ARCH_NUM;
  localparam int PW    = $clog2(DEPTH);
  localparam int IW    = $clog2(SIZE);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [IW-1:0] iprIdx_t;
  // Pointer layout: {wrap, index}. Index counts modulo DEPTH.
  typedef logic [PW:0]   ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  function automatic ptr_t ptr_add(input ptr_t p, input ptr_t n);
    ptr_t s;
    s = {1'b0, p[PW-1:0]} + n;
    if (s >= DEPTH_P) begin
      s = s - DEPTH_P;
      return {~p[PW], s[PW-1:0]};
    end
    return {p[PW], s[PW-1:0]};
  endfunction

  function automatic logic [PW-1:0] idx_add(input ptr_t p, input ptr_t n);
    ptr_t r;
    r = ptr_add(p, n);
    return r[PW-1:0];
  endfunction

  // Distance a - b; differing wrap bits mean a has lapped b once.
  function automatic ptr_t ptr_dist(input ptr_t a, input ptr_t b);
    ptr_t ai, bi;
    ai = {1'b0, a[PW-1:0]};
    bi = {1'b0, b[PW-1:0]};
    if (a[PW] == b[PW]) return ai - bi;
    return ai + DEPTH_P - bi;
  endfunction

  iprIdx_t         fifo [DEPTH];
  ptr_t            spec_head, cmt_head, tail;
  ptr_t            spec_nxt, cmt_nxt, tail_nxt;
  ptr_t            free_cnt, alloc_n, free_n;
  logic            fire;
  logic [FREE_WIDTH-1:0] free_ok;
  logic [PW-1:0]   free_wa [FREE_WIDTH];
  logic [PW-1:0]   rd_idx  [ALLOC_WIDTH];

  always_comb begin
    free_cnt     = ptr_dist(tail, spec_head);
    o_free_count = CW'(free_cnt);
    o_can_alloc  = (free_cnt >= ptr_t'(ALLOC_WIDTH));
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      rd_idx[k]         = idx_add(spec_head, ptr_t'(k));
      o_alloc_iprIdx[k] = fifo[rd_idx[k]];
    end

    alloc_n = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++)
      alloc_n = alloc_n + ptr_t'(i_alloc_vld[k]);

    // Compact valid, nonzero free lanes into consecutive slots from tail.
    free_n  = '0;
    free_ok = '0;
    for (int k = 0; k < FREE_WIDTH; k++) begin
      free_ok[k] = i_free_vld[k] && (i_free_iprIdx[k] != '0);
      free_wa[k] = idx_add(tail, free_n);
      if (free_ok[k]) free_n = free_n + ptr_t'(1);
    end

    fire     = o_can_alloc & ~i_squash;
    cmt_nxt  = ptr_add(cmt_head, ptr_t'(i_commit_cnt));
    tail_nxt = ptr_add(tail, free_n);
    if (i_squash)  spec_nxt = cmt_nxt;
    else if (fire) spec_nxt = ptr_add(spec_head, alloc_n);
    else           spec_nxt = spec_head;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_head <= '0;
      cmt_head  <= '0;
      tail      <= {1'b1, {PW{1'b0}}};
      for (int i = 0; i < DEPTH; i++)
        fifo[i] <= iprIdx_t'(ARCH_NUM + i);
    end else begin
      spec_head <= spec_nxt;
      cmt_head  <= cmt_nxt;
      tail      <= tail_nxt;
      for (int k = 0; k < FREE_WIDTH; k++)
        if (free_ok[k]) fifo[free_wa[k]] <= i_free_iprIdx[k];
    end
  end

  // Commit may only retire allocations that were actually handed out.
  a_cmt_order: assert property (@(posedge clk) disable iff (rst)
    ptr_dist(spec_head, cmt_head) >= ptr_t'(i_commit_cnt));

  // Slots from cmt_head to tail are live (free or still recoverable).
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (int'(ptr_dist(tail, cmt_head)) + int'(free_n) - int'(i_commit_cnt)) <= DEPTH);

`ifdef FREELIST_DUPCHK_EN
  logic [SIZE-1:0]       in_list;
  logic [FREE_WIDTH-1:0] dup_hit;
  ptr_t                  rec_n;
  ptr_t                  slot_ofs [DEPTH];

  always_comb begin
    rec_n   = ptr_dist(spec_head, cmt_nxt);
    dup_hit = '0;
    for (int k = 0; k < FREE_WIDTH; k++)
      dup_hit[k] = free_ok[k] & in_list[i_free_iprIdx[k]];
    // Offset of every slot from the recovered head; slots below rec_n
    // hold the entries a squash hands back.
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_t'(i) >= {1'b0, cmt_nxt[PW-1:0]})
        slot_ofs[i] = ptr_t'(i) - {1'b0, cmt_nxt[PW-1:0]};
      else
        slot_ofs[i] = ptr_t'(i) + DEPTH_P - {1'b0, cmt_nxt[PW-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++)
        in_list[i] <= (i >= ARCH_NUM);
      o_dup_err <= 1'b0;
    end else begin
      if (i_squash)
        for (int i = 0; i < DEPTH; i++)
          if (slot_ofs[i] < rec_n) in_list[fifo[i]] <= 1'b1;
      if (fire)
        for (int k = 0; k < ALLOC_WIDTH; k++)
          if (i_alloc_vld[k]) in_list[o_alloc_iprIdx[k]] <= 1'b0;
      for (int k = 0; k < FREE_WIDTH; k++)
        if (free_ok[k]) in_list[i_free_iprIdx[k]] <= 1'b1;
      if (|dup_hit) o_dup_err <= 1'b1;
    end
  end

  a_no_dup_free: assert property (@(posedge clk) disable iff (rst) dup_hit == '0);
`endif

endmodule

// File: tb/tb_int_freelist.sv
// Testbench for int_freelist: directed scenarios plus a randomized run
// checked against a queue-based model of the free list.
module tb_int_freelist;
  localparam int SIZE  = 80;
  localparam int ARCH  = 32;
  localparam int AW    = 4;
  localparam int FW    = 4;
  localparam int DEPTH = SIZE - ARCH;
  localparam int IW    = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic                   can_alloc;
  logic [AW-1:0]          alloc_vld;
  logic [AW-1:0][IW-1:0]  alloc_idx;
  logic [2:0]             commit_cnt;
  logic [FW-1:0]          free_vld;
  logic [FW-1:0][IW-1:0]  free_idx;
  logic                   squash;
  logic [5:0]             free_count;
`ifdef FREELIST_DUPCHK_EN
  logic                   dup_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model: fl = free indices in allocation order, infl = allocated but not
  // committed (oldest first), pool = committed indices available to free.
  int fl[$];
  int infl[$];
  int pool[$];

  always #5 clk = ~clk;

  int_freelist #(.SIZE(SIZE), .ARCH_NUM(ARCH), .ALLOC_WIDTH(AW), .FREE_WIDTH(FW)) dut (
    .clk(clk),
    .rst(rst),
    .o_can_alloc(can_alloc),
    .i_alloc_vld(alloc_vld),
    .o_alloc_iprIdx(alloc_idx),
    .i_commit_cnt(commit_cnt),
    .i_free_vld(free_vld),
    .i_free_iprIdx(free_idx),
    .i_squash(squash),
    .o_free_count(free_count)
`ifdef FREELIST_DUPCHK_EN
    ,.o_dup_err(dup_err)
`endif
  );

  task automatic idle();
    alloc_vld  = '0;
    commit_cnt = '0;
    free_vld   = '0;
    free_idx   = '0;
    squash     = 1'b0;
  endtask

  task automatic model_reset();
    fl.delete();
    infl.delete();
    pool.delete();
    for (int i = 0; i < DEPTH; i++) fl.push_back(ARCH + i);
  endtask

  // Advance the model by one cycle from the inputs currently driven, then
  // clock the DUT and return just after the falling edge with inputs idle.
  task automatic step();
    int n;
    repeat (int'(commit_cnt)) if (infl.size() > 0) pool.push_back(infl.pop_front());
    if (fl.size() >= AW && !squash) begin
      n = 0;
      for (int k = 0; k < AW; k++) if (alloc_vld[k]) n++;
      repeat (n) infl.push_back(fl.pop_front());
    end
    if (squash) while (infl.size() > 0) fl.push_front(infl.pop_back());
    for (int k = 0; k < FW; k++)
      if (free_vld[k] && free_idx[k] != '0) fl.push_back(int'(free_idx[k]));
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    @(negedge clk);
    n_checks++;
    if (free_count !== 6'(DEPTH)) begin n_fail++; $display("FAIL reset_count_in_rst: got %0d want %0d", free_count, DEPTH); end
    for (int k = 0; k < AW; k++) begin
      n_checks++;
      if (alloc_idx[k] !== IW'(ARCH + k)) begin n_fail++; $display("FAIL reset_idx[%0d]: got %0d want %0d", k, alloc_idx[k], ARCH + k); end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (can_alloc !== 1'b1) begin n_fail++; $display("FAIL reset_can_alloc: got %0b want 1", can_alloc); end
    n_checks++;
    if (free_count !== 6'(DEPTH)) begin n_fail++; $display("FAIL reset_count: got %0d want %0d", free_count, DEPTH); end
`ifdef FREELIST_DUPCHK_EN
    n_checks++;
    if (dup_err !== 1'b0) begin n_fail++; $display("FAIL reset_dup_err: got %0b want 0", dup_err); end
`endif
  endtask

  task automatic test_alloc_basic();
    do_reset();
    alloc_vld = 4'b1111;
    #1;
    for (int k = 0; k < AW; k++) begin
      n_checks++;
      if (alloc_idx[k] !== IW'(32 + k)) begin n_fail++; $display("FAIL alloc0_idx[%0d]: got %0d want %0d", k, alloc_idx[k], 32 + k); end
    end
    step();
    for (int k = 0; k < AW; k++) begin
      n_checks++;
      if (alloc_idx[k] !== IW'(36 + k)) begin n_fail++; $display("FAIL alloc1_idx[%0d]: got %0d want %0d", k, alloc_idx[k], 36 + k); end
    end
    n_checks++;
    if (free_count !== 6'd44) begin n_fail++; $display("FAIL alloc1_count: got %0d want 44", free_count); end
  endtask

  task automatic test_exhaust();
    do_reset();
    repeat (12) begin alloc_vld = 4'hf; step(); end
    n_checks++;
    if (free_count !== 6'd0) begin n_fail++; $display("FAIL exhaust_count: got %0d want 0", free_count); end
    n_checks++;
    if (can_alloc !== 1'b0) begin n_fail++; $display("FAIL exhaust_can_alloc: got %0b want 0", can_alloc); end
    repeat (2) begin alloc_vld = 4'hf; step(); end
    n_checks++;
    if (free_count !== 6'd0) begin n_fail++; $display("FAIL exhaust_hold_count: got %0d want 0", free_count); end
    commit_cnt = 3'd4;
    step();
    free_vld    = 4'b0001;
    free_idx[0] = IW'(35);
    step();
    n_checks++;
    if (free_count !== 6'(fl.size()) || fl.size() != 1) begin n_fail++; $display("FAIL exhaust_refill_count: got %0d want 1", free_count); end
    n_checks++;
    if (alloc_idx[0] !== IW'(35)) begin n_fail++; $display("FAIL exhaust_refill_idx: got %0d want 35", alloc_idx[0]); end
  endtask

  task automatic test_squash();
    do_reset();
    repeat (2) begin alloc_vld = 4'hf; step(); end
    commit_cnt = 3'd4;
    step();
    squash = 1'b1;
    #1;
    n_checks++;
    if (alloc_idx[0] !== IW'(40)) begin n_fail++; $display("FAIL squash_cycle_idx: got %0d want 40", alloc_idx[0]); end
    step();
    n_checks++;
    if (alloc_idx[0] !== IW'(36)) begin n_fail++; $display("FAIL squash_idx: got %0d want 36", alloc_idx[0]); end
    n_checks++;
    if (free_count !== 6'd44) begin n_fail++; $display("FAIL squash_count: got %0d want 44", free_count); end
    // Squash with a same-cycle commit and a dropped allocation.
    do_reset();
    repeat (2) begin alloc_vld = 4'hf; step(); end
    squash     = 1'b1;
    commit_cnt = 3'd2;
    alloc_vld  = 4'hf;
    step();
    n_checks++;
    if (free_count !== 6'd46) begin n_fail++; $display("FAIL squash_commit_count: got %0d want 46", free_count); end
    n_checks++;
    if (alloc_idx[0] !== IW'(34)) begin n_fail++; $display("FAIL squash_commit_idx: got %0d want 34", alloc_idx[0]); end
  endtask

  task automatic test_free_compact();
    int exp_idx[4];
    exp_idx = '{5, 7, 9, 11};
    do_reset();
    repeat (2) begin alloc_vld = 4'hf; step(); end
    repeat (2) begin commit_cnt = 3'd4; step(); end
    n_checks++;
    if (free_count !== 6'd40) begin n_fail++; $display("FAIL free_pre_count: got %0d want 40", free_count); end
    free_vld = 4'b1111;
    free_idx[0] = IW'(5);
    free_idx[1] = IW'(0);
    free_idx[2] = IW'(7);
    free_idx[3] = IW'(9);
    step();
    n_checks++;
    if (free_count !== 6'd43) begin n_fail++; $display("FAIL free_count: got %0d want 43", free_count); end
    repeat (10) begin alloc_vld = 4'hf; step(); end
    free_vld    = 4'b0001;
    free_idx[0] = IW'(11);
    step();
    n_checks++;
    if (free_count !== 6'd4) begin n_fail++; $display("FAIL free_tail_count: got %0d want 4", free_count); end
    for (int k = 0; k < AW; k++) begin
      n_checks++;
      if (alloc_idx[k] !== IW'(exp_idx[k])) begin n_fail++; $display("FAIL free_order[%0d]: got %0d want %0d", k, alloc_idx[k], exp_idx[k]); end
    end
  endtask

  task automatic test_random();
    int n, j, lim;
    do_reset();
    for (int cyc = 0; cyc < 200; cyc++) begin
      n = $urandom_range(0, AW);
      alloc_vld = AW'((1 << n) - 1);
      lim = (infl.size() < AW) ? infl.size() : AW;
      commit_cnt = 3'($urandom_range(0, lim));
      squash = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < FW; k++) begin
        if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
          j = $urandom_range(0, pool.size() - 1);
          free_vld[k] = 1'b1;
          free_idx[k] = IW'(pool[j]);
          pool.delete(j);
        end else if ($urandom_range(0, 7) == 0) begin
          free_vld[k] = 1'b1;
          free_idx[k] = '0;
        end else begin
          free_vld[k] = 1'b0;
          free_idx[k] = IW'($urandom_range(1, SIZE - 1));
        end
      end
      #1;
      n_checks++;
      if (free_count !== 6'(fl.size())) begin n_fail++; $display("FAIL rand_count cyc %0d: got %0d want %0d", cyc, free_count, fl.size()); end
      n_checks++;
      if (can_alloc !== (fl.size() >= AW)) begin n_fail++; $display("FAIL rand_can_alloc cyc %0d: got %0b want %0b", cyc, can_alloc, fl.size() >= AW); end
      for (int k = 0; k < AW; k++) begin
        if (k < fl.size()) begin
          n_checks++;
          if (alloc_idx[k] !== IW'(fl[k])) begin n_fail++; $display("FAIL rand_idx[%0d] cyc %0d: got %0d want %0d", k, cyc, alloc_idx[k], fl[k]); end
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (2) begin alloc_vld = 4'hf; step(); end
    squash     = 1'b1;
    commit_cnt = 3'd2;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (free_count !== 6'(DEPTH)) begin n_fail++; $display("FAIL midrst_count: got %0d want %0d", free_count, DEPTH); end
    n_checks++;
    if (can_alloc !== 1'b1) begin n_fail++; $display("FAIL midrst_can_alloc: got %0b want 1", can_alloc); end
    for (int k = 0; k < AW; k++) begin
      n_checks++;
      if (alloc_idx[k] !== IW'(ARCH + k)) begin n_fail++; $display("FAIL midrst_idx[%0d]: got %0d want %0d", k, alloc_idx[k], ARCH + k); end
    end
    idle();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    step();
    n_checks++;
    if (free_count !== 6'(DEPTH)) begin n_fail++; $display("FAIL midrst_post_count: got %0d want %0d", free_count, DEPTH); end
    n_checks++;
    if (alloc_idx[0] !== IW'(ARCH)) begin n_fail++; $display("FAIL midrst_post_idx: got %0d want %0d", alloc_idx[0], ARCH); end
  endtask

`ifdef FREELIST_DUPCHK_EN
  task automatic test_dup();
    do_reset();
    repeat (12) begin alloc_vld = 4'hf; step(); end
    repeat (12) begin commit_cnt = 3'd4; step(); end
    free_vld    = 4'b0001;
    free_idx[0] = IW'(40);
    step();
    n_checks++;
    if (dup_err !== 1'b0) begin n_fail++; $display("FAIL dup_first: got %0b want 0", dup_err); end
    free_vld    = 4'b0001;
    free_idx[0] = IW'(40);
    step();
    n_checks++;
    if (dup_err !== 1'b1) begin n_fail++; $display("FAIL dup_second: got %0b want 1", dup_err); end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_alloc_basic();
    test_exhaust();
    test_squash();
    test_free_compact();
    test_random();
    test_reset_mid();
`ifdef FREELIST_DUPCHK_EN
    test_dup();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
